// File: rtl/corr_search_ctrl.sv
// Raster-scan controller for the correlation search: walks a stepped (X,Y) grid,
// issues one correlation request per point and publishes the best-scoring point.
module corr_search_ctrl #(
    parameter int COORD_W   = 13,
    parameter int CORR_W    = 32,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int LED_DIV_W = 26
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic               iMode,
    input  logic [3:0]         iXStep,
    input  logic [3:0]         iYStep,
    output logic               oCorrReq,
    input  logic               iCorrFinished,
    input  logic [CORR_W-1:0]  iCurrentCorr,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic [COORD_W-1:0] oXresult,
    output logic [COORD_W-1:0] oYresult,
    output logic [CORR_W-1:0]  oBestCorr,
    output logic               oBusy,
    output logic               oDone,
    output logic               oStatusLed
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ADV, DONE} state_t;

    state_t               state, next_state;
    logic                 mode;
    logic [3:0]           xstep, ystep;
    logic [COORD_W-1:0]   best_x, best_y;
    logic [CORR_W-1:0]    best_score;
    logic                 best_valid;
    logic                 have_result;
    logic [LED_DIV_W-1:0] led_cnt;
    logic [COORD_W:0]     nx, ny;
    logic                 x_wrap, scan_end, accept;

    // One extra bit on the step sums so a wrap past the grid edge cannot alias back inside it.
    always_comb begin
        nx       = {1'b0, oX} + (COORD_W+1)'(xstep);
        ny       = {1'b0, oY} + (COORD_W+1)'(ystep);
        x_wrap   = (nx >= (COORD_W+1)'(H_RES));
        scan_end = x_wrap && (ny >= (COORD_W+1)'(V_RES));
        accept   = !best_valid ||
                   (mode ? (iCurrentCorr < best_score) : (iCurrentCorr > best_score));
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (iStart) begin
            next_state = REQ;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                REQ:     next_state = WAIT;
                WAIT:    if (iCorrFinished) next_state = ADV;
                ADV:     next_state = scan_end ? DONE : REQ;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        oCorrReq   = (state == REQ);
        oBusy      = (state != IDLE);
        oDone      = (state == DONE);
        oStatusLed = oBusy ? led_cnt[LED_DIV_W-1] : have_result;
    end

    // Results are loaded on the ADV->DONE edge so they are already visible while oDone is high.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            mode        <= 1'b0;
            xstep       <= 4'd1;
            ystep       <= 4'd1;
            oX          <= '0;
            oY          <= '0;
            best_x      <= '0;
            best_y      <= '0;
            best_score  <= '0;
            best_valid  <= 1'b0;
            oXresult    <= '0;
            oYresult    <= '0;
            oBestCorr   <= '0;
            have_result <= 1'b0;
        end else if (iStart) begin
            mode       <= iMode;
            xstep      <= (iXStep == 4'd0) ? 4'd1 : iXStep;
            ystep      <= (iYStep == 4'd0) ? 4'd1 : iYStep;
            oX         <= '0;
            oY         <= '0;
            best_valid <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (iCorrFinished && accept) begin
                        best_score <= iCurrentCorr;
                        best_x     <= oX;
                        best_y     <= oY;
                        best_valid <= 1'b1;
                    end
                end
                ADV: begin
                    if (!x_wrap) begin
                        oX <= nx[COORD_W-1:0];
                    end else if (!scan_end) begin
                        oX <= '0;
                        oY <= ny[COORD_W-1:0];
                    end else begin
                        oXresult    <= best_x;
                        oYresult    <= best_y;
                        oBestCorr   <= best_score;
                        have_result <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) led_cnt <= '0;
        else         led_cnt <= led_cnt + 1'b1;
    end

endmodule

// File: tb/tb_corr_search_ctrl.sv
// Directed bench for corr_search_ctrl: a 4x3 grid instance for scoring, restart and reset
// scenarios, and a 5x5 instance for stepped scanning.
module tb_corr_search_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start_a = 0, mode_a = 0, fin_a = 0;
    logic [3:0]  xs_a = 1, ys_a = 1;
    logic [31:0] corr_a = 0;
    logic        req_a, busy_a, done_a, led_a;
    logic [12:0] x_a, y_a, xr_a, yr_a;
    logic [31:0] best_a;

    logic        start_b = 0, mode_b = 0, fin_b = 0;
    logic [3:0]  xs_b = 1, ys_b = 1;
    logic [31:0] corr_b = 0;
    logic        req_b, busy_b, done_b, led_b;
    logic [12:0] x_b, y_b, xr_b, yr_b;
    logic [31:0] best_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    corr_search_ctrl #(.COORD_W(13), .CORR_W(32), .H_RES(4), .V_RES(3), .LED_DIV_W(4)) dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start_a), .iMode(mode_a),
        .iXStep(xs_a), .iYStep(ys_a), .oCorrReq(req_a), .iCorrFinished(fin_a),
        .iCurrentCorr(corr_a), .oX(x_a), .oY(y_a), .oXresult(xr_a), .oYresult(yr_a),
        .oBestCorr(best_a), .oBusy(busy_a), .oDone(done_a), .oStatusLed(led_a)
    );

    corr_search_ctrl #(.COORD_W(13), .CORR_W(32), .H_RES(5), .V_RES(5), .LED_DIV_W(4)) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start_b), .iMode(mode_b),
        .iXStep(xs_b), .iYStep(ys_b), .oCorrReq(req_b), .iCorrFinished(fin_b),
        .iCurrentCorr(corr_b), .oX(x_b), .oY(y_b), .oXresult(xr_b), .oYresult(yr_b),
        .oBestCorr(best_b), .oBusy(busy_b), .oDone(done_b), .oStatusLed(led_b)
    );

    function automatic logic [31:0] score(input int pat, input int x, input int y);
        case (pat)
            0:       return (x == 2 && y == 1) ? 32'd99 : 32'(10 * y + x);
            1:       return (x == 3 && y == 2) ? 32'd7 : 32'd50;
            default: return 32'd42;
        endcase
    endfunction

    task automatic pulse_start_a(input logic mode, input logic [3:0] xs, input logic [3:0] ys);
        mode_a = mode; xs_a = xs; ys_a = ys;
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
    endtask

    // Engine model for the 4x3 instance; optionally restarts during the WAIT of point stop_at.
    task automatic serve_a(input int pat, input int stop_at, output int nreq, output int ndone,
                           output int bad_order, output logic [1:0] led_seen);
        int ex = 0, ey = 0;
        nreq = 0; ndone = 0; bad_order = 0; led_seen = 2'b00;
        for (int c = 0; c < 600; c++) begin
            if (busy_a && !done_a) led_seen[led_a] = 1'b1;
            if (done_a) ndone++;
            if (req_a) begin
                nreq++;
                if (x_a !== 13'(ex) || y_a !== 13'(ey)) bad_order++;
                ex++;
                if (ex == 4) begin ex = 0; ey++; end
                @(posedge clk); #1;
                fin_a  = 1;
                corr_a = score(pat, int'(x_a), int'(y_a));
                if (stop_at != 0 && nreq == stop_at) start_a = 1;
                @(posedge clk); #1;
                fin_a = 0; start_a = 0;
                if (stop_at != 0 && nreq == stop_at) return;
            end
            if (!busy_a && ndone > 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({req_a, busy_a, done_a, led_a, x_a, y_a, xr_a, yr_a, best_a} !== '0) begin
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {req_a, busy_a, done_a, led_a, x_a, y_a, xr_a, yr_a, best_a});
        end else passes++;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if ({busy_a, req_a, led_a} !== 3'b000) begin
            $display("[TB] FAIL reset_idle: got %b expected 000", {busy_a, req_a, led_a});
        end else passes++;
    endtask

    task automatic check_scan(input string name, input int nreq, input int ndone, input int bad,
                              input int exr, input int eyr, input int ebest);
        checks++;
        if (nreq !== 12) $display("[TB] FAIL %s_requests: got %0d expected 12", name, nreq);
        else passes++;
        checks++;
        if (bad !== 0) $display("[TB] FAIL %s_raster_order: got %0d bad points expected 0", name, bad);
        else passes++;
        checks++;
        if (ndone !== 1) $display("[TB] FAIL %s_done_pulses: got %0d expected 1", name, ndone);
        else passes++;
        checks++;
        if (xr_a !== 13'(exr) || yr_a !== 13'(eyr))
            $display("[TB] FAIL %s_result_xy: got (%0d,%0d) expected (%0d,%0d)", name, xr_a, yr_a, exr, eyr);
        else passes++;
        checks++;
        if (best_a !== 32'(ebest)) $display("[TB] FAIL %s_best: got %0d expected %0d", name, best_a, ebest);
        else passes++;
    endtask

    task automatic test_max;
        int nreq, ndone, bad;
        logic [1:0] led_seen;
        pulse_start_a(1'b0, 4'd1, 4'd1);
        checks++;
        if ({busy_a, req_a, x_a, y_a} !== {2'b11, 26'd0})
            $display("[TB] FAIL start_latency: got busy=%b req=%b x=%0d y=%0d expected 1 1 0 0",
                     busy_a, req_a, x_a, y_a);
        else passes++;
        serve_a(0, 0, nreq, ndone, bad, led_seen);
        check_scan("max", nreq, ndone, bad, 2, 1, 99);
        checks++;
        if (led_seen !== 2'b11) $display("[TB] FAIL heartbeat: got seen=%b expected 11", led_seen);
        else passes++;
        checks++;
        if ({busy_a, led_a} !== 2'b01) $display("[TB] FAIL led_result_held: got busy,led=%b expected 01", {busy_a, led_a});
        else passes++;
    endtask

    task automatic test_min;
        int nreq, ndone, bad;
        logic [1:0] led_seen;
        pulse_start_a(1'b1, 4'd1, 4'd1);
        serve_a(1, 0, nreq, ndone, bad, led_seen);
        check_scan("min", nreq, ndone, bad, 3, 2, 7);
    endtask

    task automatic test_tie;
        int nreq, ndone, bad;
        logic [1:0] led_seen;
        pulse_start_a(1'b0, 4'd1, 4'd1);
        serve_a(2, 0, nreq, ndone, bad, led_seen);
        check_scan("tie", nreq, ndone, bad, 0, 0, 42);
    endtask

    task automatic test_step;
        int nreq = 0, ndone = 0, bad = 0, ex = 0, ey = 0;
        mode_b = 0; xs_b = 4'd2; ys_b = 4'd0;
        start_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        for (int c = 0; c < 600; c++) begin
            if (done_b) ndone++;
            if (req_b) begin
                nreq++;
                if (x_b !== 13'(ex) || y_b !== 13'(ey)) bad++;
                ex += 2;
                if (ex >= 5) begin ex = 0; ey++; end
                @(posedge clk); #1;
                fin_b = 1; corr_b = 32'(10 * y_b + x_b);
                @(posedge clk); #1;
                fin_b = 0;
            end
            if (!busy_b && ndone > 0) break;
            @(posedge clk); #1;
        end
        checks++;
        if (nreq !== 15) $display("[TB] FAIL step_requests: got %0d expected 15", nreq);
        else passes++;
        checks++;
        if (bad !== 0) $display("[TB] FAIL step_order: got %0d bad points expected 0", bad);
        else passes++;
        checks++;
        if (ndone !== 1 || xr_b !== 13'd4 || yr_b !== 13'd4 || best_b !== 32'd44)
            $display("[TB] FAIL step_result: got done=%0d (%0d,%0d) best=%0d expected 1 (4,4) 44",
                     ndone, xr_b, yr_b, best_b);
        else passes++;
    endtask

    task automatic test_restart;
        int nreq, ndone, bad;
        logic [1:0] led_seen;
        pulse_start_a(1'b0, 4'd1, 4'd1);
        serve_a(0, 5, nreq, ndone, bad, led_seen);
        checks++;
        if ({req_a, busy_a, x_a, y_a} !== {2'b11, 26'd0})
            $display("[TB] FAIL restart_coords: got req=%b busy=%b (%0d,%0d) expected 1 1 (0,0)",
                     req_a, busy_a, x_a, y_a);
        else passes++;
        checks++;
        if (xr_a !== 13'd0 || yr_a !== 13'd0 || best_a !== 32'd42 || ndone !== 0)
            $display("[TB] FAIL restart_results_kept: got (%0d,%0d) %0d done=%0d expected (0,0) 42 0",
                     xr_a, yr_a, best_a, ndone);
        else passes++;
        serve_a(0, 0, nreq, ndone, bad, led_seen);
        check_scan("restart", nreq, ndone, bad, 2, 1, 99);
    endtask

    task automatic test_async_reset;
        int bad_idle = 0;
        pulse_start_a(1'b0, 4'd1, 4'd1);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        checks++;
        if ({req_a, busy_a, done_a, led_a, x_a, y_a, xr_a, yr_a, best_a} !== '0)
            $display("[TB] FAIL async_reset: got %h expected 0",
                     {req_a, busy_a, done_a, led_a, x_a, y_a, xr_a, yr_a, best_a});
        else passes++;
        @(posedge clk); @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            fin_a = 1; corr_a = 32'd123;
            @(posedge clk); #1;
            if (busy_a || req_a || done_a || led_a) bad_idle++;
        end
        fin_a = 0;
        checks++;
        if (bad_idle !== 0) $display("[TB] FAIL spurious_finish: got %0d active cycles expected 0", bad_idle);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_max();
        test_min();
        test_tie();
        test_step();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
